// File: rtl/hilo_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient lands in lo, remainder in hi.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   trial;
  logic             neg_q, neg_r;
  logic             fit, accept, b_zero;

  assign b_zero = (b == '0);
  assign accept = start && (state != CALC);

  assign abs_a = (sign && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sign && b[WIDTH-1]) ? -b : b;

  // trial is one bit wider than the divisor so the compare cannot wrap
  assign trial = {rem, quo[WIDTH-1]};
  assign fit   = (trial >= {1'b0, dvs});
  assign rem_n = fit ? WIDTH'(trial - {1'b0, dvs})
                     : trial[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], fit};

  assign q_fix = neg_q ? -quo_n : quo_n;
  assign r_fix = neg_r ? -rem_n : rem_n;

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_n = b_zero ? DONE : CALC;
        else
          state_n = IDLE;
      end
      CALC: begin
        if (cnt == '0)
          state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (flush)
      state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      state <= state_n;
      if (!flush) begin
        if (accept) begin
          if (b_zero) begin
            lo       <= '1;
            hi       <= a;
            div_zero <= 1'b1;
          end else begin
            rem   <= '0;
            quo   <= abs_a;
            dvs   <= abs_b;
            neg_q <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sign && a[WIDTH-1];
            cnt   <= CW'(WIDTH - 1);
          end
        end else if (state == CALC) begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            hi       <= r_fix;
            lo       <= q_fix;
            div_zero <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// Directed and random checks for hilo_divider.
// Inputs change and outputs are sampled on the falling edge.
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        reset, start, sign, flush;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int compared = 0;
  int failed   = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sign(sign), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic s,
                        input logic [31:0] x,
                        input logic [31:0] y);
    @(negedge clk);
    sign = s; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // called at a falling edge already 'from' cycles past the start edge
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic saw;
    logic [31:0] ra, rb, eq, er;
    logic rs;

    vecs[0]  = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33};
    vecs[1]  = '{1, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33};
    vecs[2]  = '{1, 32'd7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 32'd1, 0, 33};
    vecs[3]  = '{1, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 32'd0, 0, 33};
    vecs[4]  = '{0, 32'hFFFFFFFF, 32'd1,
                 32'hFFFFFFFF, 32'd0, 0, 33};
    vecs[5]  = '{0, 32'h1234, 32'd0,
                 32'hFFFFFFFF, 32'h1234, 1, 1};
    vecs[6]  = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33};
    vecs[7]  = '{1, 32'hFFFFFFF9, 32'hFFFFFFFE,
                 32'd3, 32'hFFFFFFFF, 0, 33};
    vecs[8]  = '{0, 32'hFFFFFFF9, 32'd2,
                 32'h7FFFFFFC, 32'd1, 0, 33};
    vecs[9]  = '{0, 32'd5, 32'd9, 32'd0, 32'd5, 0, 33};
    vecs[10] = '{1, 32'h80000000, 32'd2,
                 32'hC0000000, 32'd0, 0, 33};
    vecs[11] = '{1, 32'hFFFFFFF9, 32'd0,
                 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 1};

    reset = 1'b1; start = 1'b0; sign = 1'b0;
    flush = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dz", 32'(div_zero), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    foreach (vecs[i]) begin
      launch(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(1, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].dz));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(done), 0);
    end

    // start during CALC is ignored
    launch(0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat);
    chk("ign_lat", 32'(lat), 33);
    chk("ign_lo", lo, 14);
    chk("ign_hi", hi, 2);
    @(negedge clk);
    chk("ign_pulse", 32'(done), 0);

    // start in the DONE cycle is accepted
    launch(0, 32'd100, 32'd7);
    wait_done(1, lat);
    chk("b2b_lo1", lo, 14);
    a = 32'd1000; b = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    wait_done(1, lat);
    chk("b2b_lat", 32'(lat), 33);
    chk("b2b_lo2", lo, 100);
    chk("b2b_hi2", hi, 0);

    // flush at cycle 5
    launch(0, 32'd55, 32'd5);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("fl_nodone", 32'(saw), 0);
    chk("fl_lo", lo, 100);
    chk("fl_hi", hi, 0);

    // reset at cycle 20
    launch(1, 32'hFFFFFF00, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_hi", hi, 0);
    chk("mr_lo", lo, 0);
    @(negedge clk);
    chk("mr_done", 32'(done), 0);

    // random pairs against a golden model
    for (int k = 0; k < 20; k++) begin
      rs = 1'(k % 2);
      ra = $urandom;
      rb = (k % 4 < 2) ? $urandom : 32'($urandom_range(1, 300));
      if (k % 5 == 0) rb = -rb;
      if (rb == 0) rb = 32'd3;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF)
        rb = 32'd5;
      if (rs) begin
        eq = $signed(ra) / $signed(rb);
        er = $signed(ra) % $signed(rb);
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      launch(rs, ra, rb);
      wait_done(1, lat);
      chk($sformatf("r%0d_lat", k), 32'(lat), 33);
      chk($sformatf("r%0d_lo", k), lo, eq);
      chk($sformatf("r%0d_hi", k), hi, er);
      chk($sformatf("r%0d_id", k), lo * rb + hi, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule
